formula_2_result_buffer: RTL and testbench

// - Downstream stage of the pipelined formula_2 FIFO-based computation block.
// - The formula pipe emits res_vld/res at a fixed latency and cannot be stalled.

---
 rtl/formula_2_result_buffer.sv | 145 ++++++++++++++
 tb/tb_formula_2_result_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/formula_2_result_buffer.sv
// -----------------------------------------------------------------------------
// formula_2_result_buffer
//
// Purpose:
//   Consumer-side buffer for the non-stallable formula_2 pipeline. Results that
//   arrive on res_vld/res are stored in a circular FIFO and presented on a
//   valid/ready interface. A credit counter (in_flight) tracks arguments issued
//   into the pipe but not yet popped, so upstream only launches an argument
//   when a result slot is guaranteed.
//
// Ports:
//   clk, rst_n   clock (posedge) and asynchronous active-low reset
//   arg_issue    pulse: an argument set enters the formula pipe this cycle
//   can_issue    credit available (in_flight < DEPTH)
//   res_vld/res  result strobe and data from the formula pipe
//   out_vld      FIFO not empty
//   out_data     head-of-FIFO result (0 while empty)
//   out_rdy      consumer ready; a pop happens on out_vld & out_rdy
//   in_flight    issued-but-not-popped count
//   overflow     sticky protocol-violation flag, cleared only by reset
//   res_count    delivered-result counter
//
// Configuration:
//   FORMULA_RES_BUF_STATS_EN  when defined, res_count counts pops (wrapping);
//                             when undefined, res_count is tied to 0.
// -----------------------------------------------------------------------------
module formula_2_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arg_issue,
    output logic                       can_issue,
    input  logic                       res_vld,
    input  logic [WIDTH-1:0]           res,
    output logic                       out_vld,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH+1)-1:0] in_flight,
    output logic                       overflow,
    output logic [31:0]                res_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] in_flight_q, in_flight_d;
    logic             overflow_q, overflow_d;

    logic empty, full, pop, push, issue_ok, dec;

    // Wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign pop       = !empty && out_rdy;
    // A push on full is accepted only when the same-cycle pop frees the slot.
    assign push      = res_vld && (!full || pop);
    assign can_issue = (in_flight_q < CNT_FULL);
    assign issue_ok  = arg_issue && can_issue;
    // Guard against underflow if results ever arrive without a matching issue.
    assign dec       = pop && (in_flight_q != '0);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        in_flight_d = in_flight_q;
        overflow_d  = overflow_q;

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case ({issue_ok, dec})
            2'b10:   in_flight_d = in_flight_q + 1'b1;
            2'b01:   in_flight_d = in_flight_q - 1'b1;
            default: in_flight_d = in_flight_q;
        endcase

        if ((arg_issue && !can_issue) || (res_vld && full && !pop))
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_flight_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage array carries data only; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= res;
    end

    assign out_vld   = !empty;
    // Masked while empty so out_data reads 0 under reset and never shows stale data.
    assign out_data  = empty ? '0 : mem[rd_ptr_q];
    assign in_flight = in_flight_q;
    assign overflow  = overflow_q;

`ifdef FORMULA_RES_BUF_STATS_EN
    logic [31:0] res_count_q, res_count_d;

    always_comb begin
        res_count_d = res_count_q + 32'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_count_q <= '0;
        else        res_count_q <= res_count_d;
    end

    assign res_count = res_count_q;
`else
    assign res_count = '0;
`endif

endmodule

// File: tb/tb_formula_2_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_formula_2_result_buffer
//
// Directed bench for formula_2_result_buffer (WIDTH=32, DEPTH=64). Inputs are
// driven 1 ns after each rising edge; all DUT outputs are register-derived and
// are checked at that same point, away from the active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_formula_2_result_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef FORMULA_RES_BUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             arg_issue;
    logic             can_issue;
    logic             res_vld;
    logic [WIDTH-1:0] res;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic             out_rdy;
    logic [CNT_W-1:0] in_flight;
    logic             overflow;
    logic [31:0]      res_count;

    int n_cmp = 0;
    int n_err = 0;

    formula_2_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arg_issue (arg_issue),
        .can_issue (can_issue),
        .res_vld   (res_vld),
        .res       (res),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_rdy   (out_rdy),
        .in_flight (in_flight),
        .overflow  (overflow),
        .res_count (res_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Quiet state seen during/after reset.
    task automatic chk_reset_state(input string tag);
        chk({tag, ".out_vld"},   32'(out_vld),   32'd0);
        chk({tag, ".can_issue"}, 32'(can_issue), 32'd1);
        chk({tag, ".in_flight"}, 32'(in_flight), 32'd0);
        chk({tag, ".overflow"},  32'(overflow),  32'd0);
        chk({tag, ".out_data"},  out_data,       32'd0);
        chk({tag, ".res_count"}, res_count,      32'd0);
    endtask

    // Issue DEPTH arguments with out_rdy low, then deliver DEPTH results base+i.
    task automatic fill(input logic [31:0] base);
        out_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            arg_issue = 1'b1;
            tick();
        end
        arg_issue = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            res_vld = 1'b1;
            res     = base + 32'(i);
            tick();
        end
        res_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        arg_issue = 1'b0;
        res_vld   = 1'b0;
        res       = '0;
        out_rdy   = 1'b0;

        // Reset held, then released idle.
        #2;
        chk_reset_state("in_reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk_reset_state("idle");

        // Three issues, results 10/20/30 streamed with out_rdy high.
        for (int i = 0; i < 3; i++) begin
            arg_issue = 1'b1;
            tick();
        end
        arg_issue = 1'b0;
        chk("three.in_flight", 32'(in_flight), 32'd3);
        out_rdy = 1'b1;
        res_vld = 1'b1;
        res     = 32'd10;
        chk("three.no_bypass", 32'(out_vld), 32'd0);
        tick();
        chk("three.vld0", 32'(out_vld), 32'd1);
        chk("three.d0",   out_data,      32'd10);
        res = 32'd20;
        tick();
        chk("three.d1",   out_data,       32'd20);
        chk("three.if1",  32'(in_flight), 32'd2);
        res = 32'd30;
        tick();
        chk("three.d2",   out_data,       32'd30);
        chk("three.if2",  32'(in_flight), 32'd1);
        res_vld = 1'b0;
        tick();
        chk("three.empty", 32'(out_vld),  32'd0);
        chk("three.if3",   32'(in_flight), 32'd0);

        // Credit exhaustion with consumer stalled.
        out_rdy = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            arg_issue = 1'b1;
            tick();
        end
        chk("credit.can_issue_63", 32'(can_issue), 32'd1);
        tick();
        arg_issue = 1'b0;
        chk("credit.can_issue_64", 32'(can_issue), 32'd0);
        chk("credit.in_flight",    32'(in_flight), 32'd64);
        for (int i = 0; i < DEPTH; i++) begin
            res_vld = 1'b1;
            res     = 32'd100 + 32'(i);
            tick();
        end
        res_vld = 1'b0;
        tick();
        tick();
        chk("full.out_vld",   32'(out_vld),  32'd1);
        chk("full.hold_head", out_data,      32'd100);
        chk("full.overflow",  32'(overflow), 32'd0);

        // Full FIFO: push and pop in the same cycle.
        res_vld = 1'b1;
        res     = 32'd500;
        out_rdy = 1'b1;
        tick();
        res_vld = 1'b0;
        chk("pushpop.head",      out_data,       32'd101);
        chk("pushpop.overflow",  32'(overflow),  32'd0);
        chk("pushpop.can_issue", 32'(can_issue), 32'd1);
        chk("pushpop.in_flight", 32'(in_flight), 32'd63);

        // Drain: 64 entries (101..163 then 500) prove occupancy stayed at 64.
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain.vld%0d", i), 32'(out_vld), 32'd1);
            chk($sformatf("drain.d%0d", i), out_data,
                (i < DEPTH - 1) ? 32'd101 + 32'(i) : 32'd500);
            tick();
        end
        chk("drain.empty",     32'(out_vld),   32'd0);
        chk("drain.in_flight", 32'(in_flight), 32'd0);
        chk("drain.overflow",  32'(overflow),  32'd0);
        chk("drain.res_count", res_count,      STATS ? 32'd68 : 32'd0);

        // Result on full with no pop: dropped, overflow sticky.
        fill(32'd1000);
        res_vld = 1'b1;
        res     = 32'd999;
        tick();
        res_vld = 1'b0;
        chk("drop.overflow",  32'(overflow),  32'd1);
        chk("drop.head",      out_data,       32'd1000);
        chk("drop.in_flight", 32'(in_flight), 32'd64);
        tick();
        tick();
        chk("drop.sticky",    32'(overflow),  32'd1);

        // Forced issue without credit.
        do_reset();
        chk("rst2.overflow", 32'(overflow), 32'd0);
        fill(32'd2000);
        chk("force.pre_overflow", 32'(overflow), 32'd0);
        arg_issue = 1'b1;
        tick();
        arg_issue = 1'b0;
        chk("force.overflow",  32'(overflow),  32'd1);
        chk("force.in_flight", 32'(in_flight), 32'd64);
        tick();
        chk("force.sticky",    32'(overflow),  32'd1);

        // Stats: five delivered results, then asynchronous reset mid-stream.
        do_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            arg_issue = 1'b1;
            tick();
        end
        arg_issue = 1'b0;
        for (int i = 0; i < 8; i++) begin
            res_vld = 1'b1;
            res     = 32'd300 + 32'(i);
            tick();
        end
        res_vld = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out_rdy = 1'b0;
        chk("stats.res_count", res_count,      STATS ? 32'd5 : 32'd0);
        chk("stats.head",      out_data,       32'd305);
        chk("stats.in_flight", 32'(in_flight), 32'd3);
        arg_issue = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_rst");
        arg_issue = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_state("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
